// File: rtl/rv32_prefetch_unit.sv
// Instruction prefetch queue between the instruction memory port and decode.
// Optional same-cycle bypass from memory to decode: define PREFETCH_BYPASS_EN.
module rv32_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_done,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   instr_mem_q [DEPTH];

  logic not_full, issue, push, pop, write, bypass;

  // Request side
  always_comb begin
    not_full      = (count_q != FullCnt);
    issue         = (state_q == StIdle) && not_full && !redirect_valid;
    mem_req_valid = 1'b0;
    mem_req_addr  = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        mem_req_valid = not_full && !redirect_valid;
        mem_req_addr  = fetch_pc_q;
      end
      StBusy, StDiscard: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = req_addr_q;
      end
      default: ;
    endcase
    if (!resetn) mem_req_valid = 1'b0;
    push = (issue && mem_req_done) ||
           ((state_q == StBusy) && mem_req_done && !redirect_valid);
  end

  // Decode side; a bypassed entry taken by decode is never written
  always_comb begin
`ifdef PREFETCH_BYPASS_EN
    bypass    = push && (count_q == '0);
    out_valid = resetn && ((count_q != '0) || bypass);
    out_pc    = bypass ? mem_req_addr : pc_mem_q[rd_ptr_q];
    out_instr = bypass ? mem_rdata : instr_mem_q[rd_ptr_q];
`else
    bypass    = 1'b0;
    out_valid = resetn && (count_q != '0);
    out_pc    = pc_mem_q[rd_ptr_q];
    out_instr = instr_mem_q[rd_ptr_q];
`endif
    pop   = (count_q != '0) && out_ready && !redirect_valid;
    write = push && !(bypass && out_ready);
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (push) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (issue && !mem_req_done) req_addr_d = fetch_pc_q;
    if (write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (write && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!write && pop) begin
      count_d = count_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (issue && !mem_req_done) state_d = StBusy;
      end
      StBusy: begin
        if (redirect_valid) begin
          state_d = mem_req_done ? StIdle : StDiscard;
        end else if (mem_req_done) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (mem_req_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A redirect flushes everything; any in-flight fetch drains via StDiscard
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && write) begin
      pc_mem_q[wr_ptr_q]    <= mem_req_addr;
      instr_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_rv32_prefetch_unit.sv
// Self-checking bench for rv32_prefetch_unit: expected PCs are queued per
// scenario and popped as decode accepts entries.
module tb_rv32_prefetch_unit;

  localparam logic [31:0] Key = 32'hDEAD_BEEF;
`ifdef PREFETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk, resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid, mem_req_done;
  logic [31:0] mem_req_addr, mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  int          errs = 0;
  int          checks = 0;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          first_idx, gaps;
  logic [31:0] exp_q[$];

  rv32_prefetch_unit #(
    .DEPTH    (4),
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_done   (mem_req_done),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: completes mem_wait cycles after the issue cycle
  assign mem_req_done = mem_req_valid && (wait_cnt == mem_wait);
  assign mem_rdata    = mem_req_addr ^ Key;

  always @(posedge clk) begin
    if (!resetn || !mem_req_valid || mem_req_done) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    resetn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    bit started;
    logic [31:0] e;
    n = 0;
    started = 1'b0;
    first_idx = -1;
    gaps = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      if (out_valid && out_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, e ^ Key);
        if (!started) first_idx = n;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      step();
      n++;
    end
    out_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // Back-to-back fetch with zero-wait memory
    mem_wait = 0;
    do_reset(2);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    drain(20);
    check("t1_first_idx", 32'(first_idx), Byp ? 32'd0 : 32'd1);
    check("t1_gaps", 32'(gaps), 32'd0);

    // Fill to DEPTH with decode stalled, then drain and resume
    do_reset(1);
    repeat (6) step();
    @(negedge clk);
    check("t2_full_req", 32'(mem_req_valid), 32'd0);
    check("t2_full_valid", 32'(out_valid), 32'd1);
    check("t2_full_pc", out_pc, 32'h0);
    step();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    drain(30);

    // Redirect while a slow fetch is in flight
    mem_wait = 2;
    do_reset(1);
    @(negedge clk);
    check("t3_issue_addr", mem_req_addr, 32'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_busy_addr", mem_req_addr, 32'h0);
    check("t3_busy_valid", 32'(mem_req_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_discard_addr", mem_req_addr, 32'h0);
    check("t3_discard_done", 32'(mem_req_done), 32'd1);
    check("t3_discard_out", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("t3_new_addr", mem_req_addr, 32'h100);
    step();
    exp_q = '{32'h100, 32'h104};
    drain(30);

    // Redirect coinciding with completion and a ready decode
    mem_wait = 0;
    do_reset(1);
    repeat (3) step();
    mem_wait = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_done", 32'(mem_req_done), 32'd1);
    check("t4_head_valid", 32'(out_valid), 32'd1);
    check("t4_head_pc", out_pc, 32'h0);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    mem_wait = 0;
    @(negedge clk);
    check("t4_flushed", 32'(out_valid), Byp ? 32'd1 : 32'd0);
    check("t4_req_valid", 32'(mem_req_valid), 32'd1);
    check("t4_req_addr", mem_req_addr, 32'h200);
    step();
    exp_q = '{32'h200, 32'h204, 32'h208};
    drain(30);

    // Wrap of fetch_pc past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    drain(30);

    // Reset while BUSY with two entries queued
    mem_wait = 0;
    do_reset(1);
    step();
    step();
    mem_wait = 3;
    step();
    @(negedge clk);
    check("t6_busy_valid", 32'(out_valid), 32'd1);
    check("t6_busy_head", out_pc, 32'h0);
    check("t6_busy_addr", mem_req_addr, 32'h8);
    step();
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_out", 32'(out_valid), 32'd0);
    check("t6_rst_req", 32'(mem_req_valid), 32'd0);
    step();
    resetn = 1'b1;
    mem_wait = 0;
    @(negedge clk);
    check("t6_rel_valid", 32'(mem_req_valid), 32'd1);
    check("t6_rel_addr", mem_req_addr, 32'h0);
    step();
    exp_q = '{32'h0, 32'h4};
    drain(30);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
